issue_arbiter: RTL and testbench
================================

# issue_arbiter

Multi-grant issue arbiter between the reservation-station ready vector and the functional-unit issue ports. Each cycle it selects up to NUM_GNT ready entries with a rotating-priority pointer, tells the RS which entries won, and registers the winners' indices into per-port issue slots. A slot is held until its functional unit accepts it. Built on the same multi-grant priority-select scheme the RS already uses, plus fairness and stall state.

## Interface
- NUM_REQ, 8, number of RS entries (requesters); must be ≥ 2
- NUM_GNT, 2, number of issue ports; 1 ≤ NUM_GNT ≤ NUM_REQ
- IDX_W, $clog2(NUM_REQ), index width (derived; not overridden)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NUM_REQ  bit i = RS entry i ready to issue
- fu_ready  in  NUM_GNT  port k's FU consumes slot k this cycle if slot valid
- req_gnt  out  NUM_REQ  combinational one-hot-per-winner; RS clears these entries at this edge
- slot_valid  out  NUM_GNT  registered; slot k holds an issued entry
- slot_idx  out  NUM_GNT×IDX_W  registered; RS index held in slot k

## Operation
- Slot k is free this cycle iff !slot_valid[k] || fu_ready[k].
- F = number of free slots; select up to F set bits of req, scanning circularly from ptr upward (ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1).
- Winners assigned to free slots in ascending slot order: first winner → lowest-numbered free slot.
- req_gnt has exactly the winners set; popcount(req_gnt) = min(F, popcount(req)).
- Free slot with no winner: slot_valid ← 0, slot_idx unchanged (don't care).
- Non-free slot (valid && !fu_ready): holds valid and idx.
- ptr ← (last winner index + 1) mod NUM_REQ when ≥1 grant; unchanged when no grant. Wrap computed explicitly (no reliance on power-of-2 NUM_REQ).
- req bits for entries currently held in a slot are never asserted by the RS; the arbiter does not check this.
- Reset values: slot_valid = 0, slot_idx = 0, ptr = 0; req_gnt is combinational and 0 while slots are all… free-but-req=0.

## Timing
- req → req_gnt: same cycle, combinational (req, ptr, slot_valid, fu_ready).
- req → slot_valid/slot_idx: 1-cycle latency; visible after the capturing edge.
- Back-to-back: with fu_ready all 1, a slot can reload every cycle (full throughput NUM_GNT/cycle).
- Consume and refill same edge: fu_ready[k]=1 with slot valid frees slot k for a new winner at that edge.
- All ports stalled: F=0, req_gnt=0, ptr unchanged.
- req=0: req_gnt=0, free slots drop valid, ptr unchanged.
- Reset asserted mid-operation: slots and ptr clear immediately (async); req_gnt=0 only while all req=0 — RS is also held in reset.

## Configuration
- ISSUE_ARB_ROTATE_EN defined: rotating pointer as above.
- Undefined: ptr register removed, scan always starts at index 0 (fixed priority, lowest index wins); all other behaviour identical.

## Structure
- issue_pkg: NUM_REQ, NUM_GNT defaults, IDX_W, typedef issue_slot_t {valid, idx}.
- Sub-module rr_psel: combinational multi-grant circular selector (req, start ptr, free-slot count → grant vector, per-winner indices, last-winner index).

## Test plan
- Reset, req=8'hFF, fu_ready=2'b11 → req_gnt=8'h03; next cycle slots {0:idx0, 1:idx1}, ptr=2.
- Then req=8'hFC → req_gnt=8'h0C; slots {idx2, idx3}; ptr=4.
- Wrap: ptr=6, req=8'b1000_0011 → req_gnt=8'b1000_0001; slots {idx7, idx0}; ptr=1.
- Stall: slot0 valid idx5, slot1 valid idx6, fu_ready=2'b10, req=8'h0F, ptr=0 → req_gnt=8'h01; slot0 holds idx5, slot1 ← idx0.
- Idle: req=0, fu_ready=2'b11 → req_gnt=0, slot_valid→2'b00, ptr unchanged; fu_ready=0 with both valid → nothing granted.
- Async reset pulse mid-stream → slot_valid=0, ptr=0 before next edge; without ISSUE_ARB_ROTATE_EN, req=8'hFF every cycle always grants 8'h03.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared definitions for the issue arbiter: default sizing, the issue-slot
// record handed to functional units, and a small population-count helper.
package issue_pkg;

  // Default configuration: 8 reservation-station entries, 2 issue ports.
  localparam int NUM_REQ = 8;
  localparam int NUM_GNT = 2;
  localparam int IDX_W   = $clog2(NUM_REQ);

  // One issue slot as seen by a functional unit.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } issue_slot_t;

  // Number of set bits in a vector of up to 32 bits.
  function automatic int unsigned count_ones(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_psel.sv
// rr_psel: combinational multi-grant circular priority selector.
// Scans req starting at 'start' and wrapping around, picking at most
// 'free_cnt' set bits. Winners are reported both as a grant vector and as
// an ordered list of indices (first winner in slot 0 of the list).
module rr_psel #(
  parameter int NUM_REQ = 8,
  parameter int NUM_GNT = 2,
  localparam int IDX_W  = $clog2(NUM_REQ),
  localparam int CNT_W  = $clog2(NUM_GNT + 1)
) (
  input  logic [NUM_REQ-1:0]       req,
  input  logic [IDX_W-1:0]         start,
  input  logic [CNT_W-1:0]         free_cnt,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_GNT*IDX_W-1:0] win_idx,
  output logic [CNT_W-1:0]         win_cnt,
  output logic [IDX_W-1:0]         last_idx
);

  // Circular scan; the wrap is an explicit subtract so NUM_REQ need not be a power of two.
  always_comb begin
    int pos;
    int cnt;
    gnt      = '0;
    win_idx  = '0;
    last_idx = '0;
    cnt      = 0;
    pos      = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      pos = int'(start) + o;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (req[pos] && (cnt < int'(free_cnt))) begin
        gnt[pos]                         = 1'b1;
        win_idx[cnt*IDX_W +: IDX_W]      = IDX_W'(pos);
        last_idx                         = IDX_W'(pos);
        cnt                              = cnt + 1;
      end
    end
    win_cnt = CNT_W'(cnt);
  end

endmodule

// File: rtl/issue_arbiter.sv
// issue_arbiter: picks up to NUM_GNT ready RS entries per cycle and loads
// their indices into per-port issue slots, which hold until the FU accepts.
// Build option: define ISSUE_ARB_ROTATE_EN for a rotating priority pointer;
// without it the scan always starts at entry 0 (fixed priority).
module issue_arbiter #(
  parameter int NUM_REQ = issue_pkg::NUM_REQ,
  parameter int NUM_GNT = issue_pkg::NUM_GNT,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_GNT-1:0]       fu_ready,
  output logic [NUM_REQ-1:0]       req_gnt,
  output logic [NUM_GNT-1:0]       slot_valid,
  output logic [NUM_GNT*IDX_W-1:0] slot_idx
);

  import issue_pkg::*;

  localparam int CNT_W = $clog2(NUM_GNT + 1);

  logic [NUM_GNT-1:0]       slot_valid_q, slot_valid_d;
  logic [NUM_GNT*IDX_W-1:0] slot_idx_q, slot_idx_d;
  logic [NUM_GNT-1:0]       slot_free;
  logic [CNT_W-1:0]         free_cnt;
  logic [IDX_W-1:0]         scan_start;
  logic [NUM_GNT*IDX_W-1:0] win_idx;
  logic [CNT_W-1:0]         win_cnt;
  logic [IDX_W-1:0]         last_idx;

  // A slot can take a new entry if it is empty or its FU drains it this edge.
  generate
    for (genvar gi = 0; gi < NUM_GNT; gi++) begin : g_free
      assign slot_free[gi] = !slot_valid_q[gi] || fu_ready[gi];
    end
  endgenerate

  assign free_cnt = CNT_W'(count_ones(32'(slot_free)));

  rr_psel #(
    .NUM_REQ (NUM_REQ),
    .NUM_GNT (NUM_GNT)
  ) u_psel (
    .req      (req),
    .start    (scan_start),
    .free_cnt (free_cnt),
    .gnt      (req_gnt),
    .win_idx  (win_idx),
    .win_cnt  (win_cnt),
    .last_idx (last_idx)
  );

`ifdef ISSUE_ARB_ROTATE_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Advance the pointer just past the last winner; hold it when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (win_cnt != '0) begin
      if (last_idx == IDX_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = last_idx + IDX_W'(1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign scan_start = ptr_q;
`else
  logic unused_last_idx;

  assign scan_start      = '0;
  assign unused_last_idx = ^last_idx;
`endif

  // Hand winners to free slots in ascending slot order; stalled slots hold.
  always_comb begin
    int w;
    slot_valid_d = slot_valid_q;
    slot_idx_d   = slot_idx_q;
    w            = 0;
    for (int k = 0; k < NUM_GNT; k++) begin
      if (slot_free[k]) begin
        if (w < int'(win_cnt)) begin
          slot_valid_d[k]                = 1'b1;
          slot_idx_d[k*IDX_W +: IDX_W]   = win_idx[w*IDX_W +: IDX_W];
          w                              = w + 1;
        end else begin
          slot_valid_d[k] = 1'b0;
        end
      end
    end
  end

  // Issue slot registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_valid_q <= '0;
      slot_idx_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_idx_q   <= slot_idx_d;
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_idx   = slot_idx_q;

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed testbench for issue_arbiter (NUM_REQ=8, NUM_GNT=2). Expected
// values are hand-derived for both the rotating and fixed-priority builds.
module tb_issue_arbiter;

`ifdef ISSUE_ARB_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic [1:0] fu_ready;
  logic [7:0] req_gnt;
  logic [1:0] slot_valid;
  logic [5:0] slot_idx;

  int vecs;
  int bad;

  issue_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .fu_ready   (fu_ready),
    .req_gnt    (req_gnt),
    .slot_valid (slot_valid),
    .slot_idx   (slot_idx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Apply inputs and let the combinational grant settle (stays clear of edges).
  task automatic drive(input logic [7:0] r, input logic [1:0] f);
    req      = r;
    fu_ready = f;
    #2;
  endtask

  // Advance one clock edge and sample registered outputs 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
    $display("txn req=%h fu_ready=%b -> slot_valid=%b slot1=%0d slot0=%0d",
             req, fu_ready, slot_valid, slot_idx[5:3], slot_idx[2:0]);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'h00; fu_ready = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    vecs++; if (slot_valid !== 2'b00) begin bad++; $display("FAIL reset_valid actual=%b required=00", slot_valid); end
    vecs++; if (slot_idx !== 6'd0) begin bad++; $display("FAIL reset_idx actual=%h required=00", slot_idx); end
    vecs++; if (req_gnt !== 8'h00) begin bad++; $display("FAIL reset_gnt actual=%h required=00", req_gnt); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    drive(8'hFF, 2'b11);
    vecs++; if (req_gnt !== 8'h03) begin bad++; $display("FAIL basic_gnt0 actual=%h required=03", req_gnt); end
    tick();
    exp = {2'b11, 3'd1, 3'd0};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL basic_slots0 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
    drive(8'hFC, 2'b11);
    vecs++; if (req_gnt !== 8'h0C) begin bad++; $display("FAIL basic_gnt1 actual=%h required=0c", req_gnt); end
    tick();
    exp = {2'b11, 3'd3, 3'd2};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL basic_slots1 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    drive(8'h30, 2'b11);
    vecs++; if (req_gnt !== 8'h30) begin bad++; $display("FAIL wrap_gnt0 actual=%h required=30", req_gnt); end
    tick();
    exp = {2'b11, 3'd5, 3'd4};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL wrap_slots0 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
    // Pointer sits at 6 in the rotating build: scan 6,7,0 picks 7 then 0.
    drive(8'b1000_0011, 2'b11);
    exp = ROT ? 8'h81 : 8'h03;
    vecs++; if (req_gnt !== exp) begin bad++; $display("FAIL wrap_gnt1 actual=%h required=%h", req_gnt, exp); end
    tick();
    exp = ROT ? {2'b11, 3'd0, 3'd7} : {2'b11, 3'd1, 3'd0};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL wrap_slots1 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
    // Pointer now 1: entry 1 wins before entry 0.
    drive(8'h03, 2'b11);
    vecs++; if (req_gnt !== 8'h03) begin bad++; $display("FAIL wrap_gnt2 actual=%h required=03", req_gnt); end
    tick();
    exp = ROT ? {2'b11, 3'd0, 3'd1} : {2'b11, 3'd1, 3'd0};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL wrap_slots2 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    drive(8'h60, 2'b11);
    vecs++; if (req_gnt !== 8'h60) begin bad++; $display("FAIL stall_gnt0 actual=%h required=60", req_gnt); end
    tick();
    exp = {2'b11, 3'd6, 3'd5};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL stall_slots0 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
    // Both ports stalled: nothing granted, slots hold.
    drive(8'h0F, 2'b00);
    vecs++; if (req_gnt !== 8'h00) begin bad++; $display("FAIL stall_gnt1 actual=%h required=00", req_gnt); end
    tick();
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL stall_slots1 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
    // Only port 1 drains: slot0 keeps 5, slot1 refills with entry 0.
    drive(8'h0F, 2'b10);
    vecs++; if (req_gnt !== 8'h01) begin bad++; $display("FAIL stall_gnt2 actual=%h required=01", req_gnt); end
    tick();
    exp = {2'b11, 3'd0, 3'd5};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL stall_slots2 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
  endtask

  task automatic test_idle();
    logic [7:0] exp;
    drive(8'h00, 2'b11);
    vecs++; if (req_gnt !== 8'h00) begin bad++; $display("FAIL idle_gnt0 actual=%h required=00", req_gnt); end
    tick();
    vecs++; if (slot_valid !== 2'b00) begin bad++; $display("FAIL idle_valid actual=%b required=00", slot_valid); end
    // Pointer unchanged at 1 in the rotating build.
    drive(8'h03, 2'b11);
    vecs++; if (req_gnt !== 8'h03) begin bad++; $display("FAIL idle_gnt1 actual=%h required=03", req_gnt); end
    tick();
    exp = ROT ? {2'b11, 3'd0, 3'd1} : {2'b11, 3'd1, 3'd0};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL idle_slots1 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
    drive(8'hFF, 2'b00);
    vecs++; if (req_gnt !== 8'h00) begin bad++; $display("FAIL idle_gnt2 actual=%h required=00", req_gnt); end
    tick();
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL idle_slots2 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
    // Consume and refill on port 0 only.
    drive(8'h0C, 2'b01);
    vecs++; if (req_gnt !== 8'h04) begin bad++; $display("FAIL idle_gnt3 actual=%h required=04", req_gnt); end
    tick();
    exp = ROT ? {2'b11, 3'd0, 3'd2} : {2'b11, 3'd1, 3'd2};
    vecs++; if ({slot_valid, slot_idx} !== exp) begin bad++; $display("FAIL idle_slots3 actual=%h required=%h", {slot_valid, slot_idx}, exp); end
  endtask

  task automatic test_async_reset();
    req = 8'h00; fu_ready = 2'b00;
    reset = 1'b1;
    #1;
    vecs++; if ({slot_valid, slot_idx} !== 8'h00) begin bad++; $display("FAIL areset_slots actual=%h required=00", {slot_valid, slot_idx}); end
    vecs++; if (req_gnt !== 8'h00) begin bad++; $display("FAIL areset_gnt actual=%h required=00", req_gnt); end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_g [5];
    logic [5:0] exp_s [5];
    exp_g = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};
    exp_s = '{{3'd1, 3'd0}, {3'd3, 3'd2}, {3'd5, 3'd4}, {3'd7, 3'd6}, {3'd1, 3'd0}};
    for (int c = 0; c < 5; c++) begin
      logic [7:0] eg;
      logic [7:0] es;
      eg = ROT ? exp_g[c] : 8'h03;
      es = ROT ? {2'b11, exp_s[c]} : {2'b11, 3'd1, 3'd0};
      drive(8'hFF, 2'b11);
      vecs++; if (req_gnt !== eg) begin bad++; $display("FAIL b2b_gnt%0d actual=%h required=%h", c, req_gnt, eg); end
      tick();
      vecs++; if ({slot_valid, slot_idx} !== es) begin bad++; $display("FAIL b2b_slots%0d actual=%h required=%h", c, {slot_valid, slot_idx}, es); end
    end
  endtask

  initial begin
    vecs = 0;
    bad  = 0;
    test_reset();
    @(posedge clock);
    #1;
    test_basic();
    test_wrap();
    test_stall();
    test_idle();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
